// File: rtl/if_fd_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds stall_cnt / flush_cnt event counters.
module if_fd_stage #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            PC_EN_IF,
  input  logic            reg_FD_EN,
  input  logic            reg_FD_stall,
  input  logic            reg_FD_flush,
  input  logic            Branch_ID,
  input  logic [XLEN-1:0] PC_branch_ID,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PC_IF,
  output logic [XLEN-1:0] PC_ID,
  output logic [31:0]     inst_ID,
  output logic            valid_ID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic            hold_en;
  logic [XLEN-1:0] pc_if_q, pc_if_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d;
  logic            valid_id_q, valid_id_d;
  logic            hold_q, hold_d;
  logic [31:0]     inst_buf_q, inst_buf_d;

  assign hold_en = reg_FD_stall | ~reg_FD_EN;

  always_comb begin
    pc_if_d = pc_if_q;
    if (PC_EN_IF) begin
      pc_if_d = Branch_ID ? PC_branch_ID : pc_if_q + XLEN'(4);
    end
  end

  // Hold wins over flush: the branch is resolved again once the stall clears.
  always_comb begin
    pc_id_d    = pc_id_q;
    valid_id_d = valid_id_q;
    if (!hold_en) begin
      pc_id_d    = pc_if_q;
      valid_id_d = ~reg_FD_flush;
    end
  end

  // The memory re-reads the held PC during a stall, so capture the ID word on the first hold edge only.
  always_comb begin
    hold_d     = hold_q;
    inst_buf_d = inst_buf_q;
    if (hold_en) begin
      if (!hold_q) begin
        inst_buf_d = imem_rdata;
        hold_d     = 1'b1;
      end
    end else begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_if_q    <= RESET_PC;
      pc_id_q    <= RESET_PC;
      valid_id_q <= 1'b0;
      hold_q     <= 1'b0;
      inst_buf_q <= NOP_INST;
    end else begin
      pc_if_q    <= pc_if_d;
      pc_id_q    <= pc_id_d;
      valid_id_q <= valid_id_d;
      hold_q     <= hold_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  assign imem_addr = pc_if_q;
  assign PC_IF     = pc_if_q;
  assign PC_ID     = pc_id_q;
  assign valid_ID  = valid_id_q;

  always_comb begin
    inst_ID = imem_rdata;
    if (!valid_id_q) begin
      inst_ID = NOP_INST;
    end else if (hold_q) begin
      inst_ID = inst_buf_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_en) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else if (reg_FD_flush) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fd_stage.sv
// Directed bench for if_fd_stage with a synchronous instruction memory model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_if_fd_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, Branch_ID;
  logic [31:0] PC_branch_ID;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] PC_IF, PC_ID, inst_ID;
  logic        valid_ID;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  if_fd_stage dut (
    .clk         (clk),
    .rstn        (rstn),
    .PC_EN_IF    (PC_EN_IF),
    .reg_FD_EN   (reg_FD_EN),
    .reg_FD_stall(reg_FD_stall),
    .reg_FD_flush(reg_FD_flush),
    .Branch_ID   (Branch_ID),
    .PC_branch_ID(PC_branch_ID),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .PC_IF       (PC_IF),
    .PC_ID       (PC_ID),
    .inst_ID     (inst_ID),
    .valid_ID    (valid_ID)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return 32'hA500_0000 ^ a;
  endfunction

  always @(posedge clk) imem_rdata <= mem_val(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic pc_en, input logic fd_en, input logic stall,
                     input logic flush, input logic br, input logic [31:0] tgt);
    PC_EN_IF     = pc_en;
    reg_FD_EN    = fd_en;
    reg_FD_stall = stall;
    reg_FD_flush = flush;
    Branch_ID    = br;
    PC_branch_ID = tgt;
  endtask

  initial begin
    rstn = 1'b0;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    #12;
    chk("rst_pc_if", PC_IF, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_pc_id", PC_ID, 32'd0);
    chk("rst_valid", {31'd0, valid_ID}, 32'd0);
    chk("rst_inst", inst_ID, NOP);
    chk("rst_hold", {31'd0, dut.hold_q}, 32'd0);
    rstn = 1'b1;

    step();
    chk("c1_pc_id", PC_ID, 32'd0);
    chk("c1_inst", inst_ID, 32'h0050_0093);
    chk("c1_valid", {31'd0, valid_ID}, 32'd1);
    chk("c1_pc_if", PC_IF, 32'd4);
    step();
    chk("c2_pc_if", PC_IF, 32'd8);
    chk("c2_inst", inst_ID, mem_val(32'd4));
    step();
    chk("c3_pc_if", PC_IF, 32'd12);
    chk("c3_pc_id", PC_ID, 32'd8);
    chk("c3_inst", inst_ID, mem_val(32'd8));

    // one-cycle load-use stall
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk("st1_pc_id", PC_ID, 32'd8);
    chk("st1_inst", inst_ID, mem_val(32'd8));
    chk("st1_pc_if", PC_IF, 32'd12);
    chk("st1_hold", {31'd0, dut.hold_q}, 32'd1);
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("st1_rel_pc_id", PC_ID, 32'd12);
    chk("st1_rel_inst", inst_ID, mem_val(32'd12));
    chk("st1_rel_pc_if", PC_IF, 32'd16);

    // three-cycle stall through reg_FD_EN=0
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_pc_id", PC_ID, 32'd12);
      chk("en_inst", inst_ID, mem_val(32'd12));
      chk("en_rdata", imem_rdata, mem_val(32'd16));
    end
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("en_rel_pc_id", PC_ID, 32'd16);
    chk("en_rel_inst", inst_ID, mem_val(32'd16));

    // taken branch with flush
    ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
    step();
    chk("br_valid", {31'd0, valid_ID}, 32'd0);
    chk("br_inst", inst_ID, NOP);
    chk("br_pc_if", PC_IF, 32'h40);
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("br_tgt_pc_id", PC_ID, 32'h40);
    chk("br_tgt_valid", {31'd0, valid_ID}, 32'd1);
    chk("br_tgt_inst", inst_ID, mem_val(32'h40));

    // stall and flush on the same edge
    ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step();
    chk("sf_valid", {31'd0, valid_ID}, 32'd1);
    chk("sf_pc_id", PC_ID, 32'h40);
    chk("sf_inst", inst_ID, mem_val(32'h40));
`ifdef FETCH_PERF_CNT_EN
    chk("sf_stall_cnt", stall_cnt, 32'd5);
    chk("sf_flush_cnt", flush_cnt, 32'd1);
`endif
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("sf_rel_pc_id", PC_ID, 32'h44);
    chk("sf_rel_inst", inst_ID, mem_val(32'h44));

    // PC wrap
    ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    chk("wr_pc_if_top", PC_IF, 32'hFFFF_FFFC);
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("wr_pc_if_zero", PC_IF, 32'd0);
    chk("wr_pc_id", PC_ID, 32'hFFFF_FFFC);
    chk("wr_inst", inst_ID, mem_val(32'hFFFF_FFFC));
`ifdef FETCH_PERF_CNT_EN
    chk("wr_flush_cnt", flush_cnt, 32'd2);
`endif
    step();
    chk("wr_pc_if_4", PC_IF, 32'd4);

    // reset asserted mid-stall
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk("ms_hold", {31'd0, dut.hold_q}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ms_pc_if", PC_IF, 32'd0);
    chk("ms_pc_id", PC_ID, 32'd0);
    chk("ms_valid", {31'd0, valid_ID}, 32'd0);
    chk("ms_hold0", {31'd0, dut.hold_q}, 32'd0);
    chk("ms_inst", inst_ID, NOP);
`ifdef FETCH_PERF_CNT_EN
    chk("ms_stall_cnt", stall_cnt, 32'd0);
    chk("ms_flush_cnt", flush_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fd_stage.md
# if_fd_stage

Instruction-fetch stage with the IF/ID pipeline register. It is the consumer of the pipeline control outputs of the hazard detection unit: PC enable, FD enable, FD stall and FD flush. It owns the PC and drives a synchronous (1-cycle read latency) instruction memory. Because that memory re-reads the held PC during a stall, the block keeps the stalled ID instruction in an internal hold buffer so the ID stage sees a stable instruction.

## Interface
Parameters:
- XLEN, 32, PC/data width
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INST, 32'h0000_0013, instruction presented to ID when the stage is invalid or flushed

Ports:
- clk  in  1  single clock; all state updates on posedge
- rstn  in  1  asynchronous, active-low reset
- PC_EN_IF  in  1  PC advance enable from hazard unit
- reg_FD_EN  in  1  IF/ID register enable; 0 behaves as a stall
- reg_FD_stall  in  1  hold IF/ID contents
- reg_FD_flush  in  1  invalidate IF/ID on next edge
- Branch_ID  in  1  taken branch/jump resolved in ID
- PC_branch_ID  in  XLEN  branch target
- imem_addr  out  XLEN  instruction memory address; always equals PC_IF
- imem_rdata  in  32  memory data for the address sampled on the previous edge
- PC_IF  out  XLEN  current fetch PC
- PC_ID  out  XLEN  PC of the instruction in ID
- inst_ID  out  32  instruction in ID
- valid_ID  out  1  ID holds a real instruction

## Operation
- hold_en = reg_FD_stall | ~reg_FD_EN.
- PC update:
  - if PC_EN_IF=1: PC_IF <= Branch_ID ? PC_branch_ID : PC_IF+4, with wrap modulo 2^XLEN.
  - if PC_EN_IF=0: PC_IF holds.
- IF/ID register, priority in this order:
  1. hold_en: PC_ID and valid_ID hold. Flush is ignored; the branch re-resolves after the stall.
  2. reg_FD_flush: valid_ID <= 0, PC_ID <= PC_IF.
  3. otherwise: PC_ID <= PC_IF, valid_ID <= 1.
- Hold buffer state (hold_q, inst_buf):
  - on an edge with hold_en=1 and hold_q=0: inst_buf <= imem_rdata, hold_q <= 1.
  - on an edge with hold_en=1 and hold_q=1: no change.
  - on an edge with hold_en=0: hold_q <= 0.
- inst_ID selection:
  - NOP_INST if valid_ID=0.
  - else inst_buf if hold_q=1.
  - else imem_rdata.
- PC_EN_IF=1 while hold_en=1 is legal. PC_IF advances and the instruction at the old PC_IF is lost. The hazard unit must never do this.

## Timing
- Reset (rstn=0, asynchronous): PC_IF=RESET_PC, imem_addr=RESET_PC, PC_ID=RESET_PC, valid_ID=0, inst_ID=NOP_INST, hold_q=0, inst_buf=NOP_INST.
- First edge after rstn rises: PC_ID=RESET_PC, valid_ID=1, inst_ID=mem[RESET_PC], PC_IF=RESET_PC+4.
- Fetch-to-ID latency is 1 cycle. Branch penalty is 1 bubble: the edge with Branch_ID=1 and reg_FD_flush=1 loads the target into PC_IF and a bubble into ID.
- Stall of N cycles: inst_ID and PC_ID are constant for N+1 cycles. On the release edge ID receives the instruction at the held PC_IF, with no duplicate and no skip.
- Back-to-back stalls are permitted. A stall and a flush on the same edge resolve as stall.
- Reset asserted mid-stall or mid-flush returns all state to the reset values immediately.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs stall_cnt [31:0] and flush_cnt [31:0].
  - Both counters reset to 0.
  - stall_cnt increments on every edge with hold_en=1.
  - flush_cnt increments on every edge where the flush branch is taken.
  - Both wrap at 2^32.
- FETCH_PERF_CNT_EN undefined: the ports and logic are absent; the remaining behaviour is identical.

## Test plan
- Reset release with mem[0]=32'h00500093: cycle 1 shows PC_ID=0, inst_ID=32'h00500093, valid_ID=1; PC_IF steps 4, 8, 12 on the following edges.
- Load-use stall for 1 cycle, applied at PC_ID=8 (PC_EN_IF=0, reg_FD_stall=1):
  - PC_ID=8 and inst_ID=mem[8] for 2 cycles.
  - Then PC_ID=12, inst_ID=mem[12].
  - No duplicate instruction.
- 3-cycle stall via reg_FD_EN=0: inst_ID equals mem[PC_ID] throughout, while imem_rdata shows mem[PC_ID+4].
- Branch_ID=1 and reg_FD_flush=1 at PC_ID=16 with target 32'h40:
  - Next cycle: valid_ID=0, inst_ID=32'h00000013, PC_IF=32'h40.
  - Following cycle: PC_ID=32'h40.
- reg_FD_stall=1 and reg_FD_flush=1 on the same edge: valid_ID stays 1 and PC_ID holds. With FETCH_PERF_CNT_EN, stall_cnt increments by 1 and flush_cnt does not change.
- Wrap and reset checks:
  - PC_IF=32'hFFFF_FFFC with PC_EN_IF=1 wraps to 0.
  - Asserting rstn=0 mid-stall immediately gives PC_IF=RESET_PC, valid_ID=0, hold_q=0.
